alu_cmd_driver: RTL

- Sequential command front-end that sits on the operand side of the 4-bit combinational ALU (ports inA, inB, op, ans).
- Accepts packed ALU commands over a valid/ready interface and drives the ALU operand and opcode inputs from registers.
- Captures the ALU result one cycle later and returns it over a valid/ready response interface.
- Keeps an accumulator so chained operations can reuse the previous result, and counts completed operations.

---
 rtl/alu_cmd_driver.sv | 128 ++++++++++++
 1 files changed

// File: rtl/alu_cmd_driver.sv
// Valid/ready command front-end for the 4-bit combinational ALU: registers operands,
// captures the ALU answer one cycle later, returns it, and keeps an accumulator and op counter.
module alu_cmd_driver #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_acc,
    output logic [WIDTH-1:0] alu_inA,
    output logic [WIDTH-1:0] alu_inB,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_ans,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [1:0]       rsp_op,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic             cmd_fire_s;
    logic             capture_s;
    logic             rsp_fire_s;
    logic [WIDTH-1:0] alu_ina_r;
    logic [WIDTH-1:0] alu_inb_r;
    logic [1:0]       alu_op_r;
    logic             rsp_valid_r;
    logic [WIDTH-1:0] rsp_data_r;
    logic [1:0]       rsp_op_r;
    logic [WIDTH-1:0] acc_r;
    logic [CNT_W-1:0] op_count_r;

    // cmd_ready is the only combinational output; it must drop while reset is held
    assign cmd_ready = (state_r == IDLE) && reset_n;
    assign alu_inA   = alu_ina_r;
    assign alu_inB   = alu_inb_r;
    assign alu_op    = alu_op_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_op    = rsp_op_r;
    assign op_count  = op_count_r;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-state strobes
    always_comb begin
        state_s    = state_r;
        cmd_fire_s = 1'b0;
        capture_s  = 1'b0;
        rsp_fire_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    cmd_fire_s = 1'b1;
                    state_s    = DRIVE;
                end else begin
                    state_s    = IDLE;
                end
            end
            DRIVE: begin
                capture_s = 1'b1;
                state_s   = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_fire_s = 1'b1;
                    state_s    = IDLE;
                end else begin
                    state_s    = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Operand, response, accumulator and counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_ina_r   <= {WIDTH{1'b0}};
            alu_inb_r   <= {WIDTH{1'b0}};
            alu_op_r    <= 2'b00;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {WIDTH{1'b0}};
            rsp_op_r    <= 2'b00;
            acc_r       <= {WIDTH{1'b0}};
            op_count_r  <= {CNT_W{1'b0}};
        end else begin
            if (cmd_fire_s) begin
                alu_op_r  <= cmd_op;
                alu_inb_r <= cmd_b;
                alu_ina_r <= cmd_acc ? acc_r : cmd_a;
            end
            // The ALU is combinational, so its answer is valid for the whole DRIVE cycle
            if (capture_s) begin
                rsp_data_r  <= alu_ans;
                rsp_op_r    <= alu_op_r;
                acc_r       <= alu_ans;
                op_count_r  <= op_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                rsp_valid_r <= 1'b1;
            end else if (rsp_fire_s) begin
                rsp_valid_r <= 1'b0;
            end
        end
    end

endmodule
